// File: rtl/bool_pkg.sv
// Shared types and constants for the boolean gate sweep stage.
// State encoding, vector width and the reference truth table.
package bool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int VEC_W = 3;

  // Truth table of e = ~((a&b)|c), bit i for {a,b,c} = i
  localparam logic [7:0] EXP_BOOL2B = 8'h15;

endpackage

// File: rtl/bool_sweep_step_timer.sv
// Per-vector hold counter for the sweep stage.
// Emits the sample strobe at SETTLE and the step-end strobe at DIV-1.
module step_timer #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_sample_now,
  output logic o_step_end
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_sample_now = i_run && (r_cnt == CW'(SETTLE));
  assign o_step_end   = i_run && (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_step_end) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bool_sweep.sv
// Drives all eight {a,b,c} vectors into the gate stage and captures
// the e response of each into a truth table checked against EXP.
module bool_sweep
  import bool_pkg::*;
#(
  parameter int unsigned DIV    = 4,
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXP    = EXP_BOOL2B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_e,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_table,
  output logic       o_match
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_idx;
  logic [VEC_W-1:0] w_idx_nxt;
  logic [VEC_W-1:0] r_vec;
  logic [VEC_W-1:0] w_vec_nxt;
  logic [7:0]       r_table;
  logic [7:0]       w_table_nxt;
  logic             r_match;
  logic             w_match_nxt;
  logic             w_accept;
  logic             w_run;
  logic             w_sample;
  logic             w_step_end;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_run    = (r_state == RUN);

  step_timer #(
    .DIV    (DIV),
    .SETTLE (SETTLE)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_accept),
    .i_run        (w_run),
    .o_sample_now (w_sample),
    .o_step_end   (w_step_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_vec_nxt   = r_vec;
    w_table_nxt = r_table;
    w_match_nxt = r_match;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
          w_vec_nxt   = '0;
          w_table_nxt = '0;
          w_match_nxt = 1'b0;
        end
      end
      RUN: begin
        if (w_sample) begin
          w_table_nxt[r_idx] = i_e;
        end
        if (w_step_end) begin
          // DIV=1 samples and steps on the same edge, so compare
          // against the table including this cycle's capture.
          if (r_idx == '1) begin
            w_state_nxt = DONE;
            w_match_nxt = (w_table_nxt == EXP);
          end else begin
            w_idx_nxt = r_idx + VEC_W'(1);
            w_vec_nxt = r_idx + VEC_W'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_table <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_vec   <= w_vec_nxt;
      r_table <= w_table_nxt;
      r_match <= w_match_nxt;
    end
  end

  assign o_a     = r_vec[2];
  assign o_b     = r_vec[1];
  assign o_c     = r_vec[0];
  assign o_busy  = (r_state != IDLE);
  assign o_done  = (r_state == DONE);
  assign o_table = r_table;
  assign o_match = r_match;

endmodule
